exit_status_monitor: RTL

EXIT_STATUS_MONITOR -- requirements
Module: exit_status_monitor

---
 rtl/exit_mon_pkg.sv | 20 ++
 rtl/exit_mon_filter.sv | 38 +++
 rtl/exit_status_monitor.sv | 127 ++++++++++++
 3 files changed

// File: rtl/exit_mon_pkg.sv
// Shared types and exit-code helpers for the exit status monitor.
package exit_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned EXIT_NONE = 0;

    function automatic int unsigned chan_code(input int unsigned k);
        return k + 1;
    endfunction

    function automatic int unsigned timeout_code(input int unsigned nb_ch);
        return nb_ch + 1;
    endfunction

endpackage

// File: rtl/exit_mon_filter.sv
// Persistence filter for one exit-event channel: confirms after PERSIST_CYC
// consecutive asserted cycles while enabled.
module exit_mon_filter #(
    parameter int unsigned PERSIST_CYC = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic event_i,
    output logic confirm_o
);

    localparam int unsigned CntW = $clog2(PERSIST_CYC + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(PERSIST_CYC);
    localparam logic [CntW-1:0] CntLast = CntW'(PERSIST_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || !event_i) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign confirm_o = en_i && event_i && (cnt_q == CntLast);

endmodule

// File: rtl/exit_status_monitor.sv
// Run monitor: waits for a persistent exit event or a cycle timeout, then latches
// an exit code. Define EXIT_MON_CYCLE_SNAPSHOT_EN to capture the exit cycle count.
module exit_status_monitor
    import exit_mon_pkg::*;
#(
    parameter int unsigned NB_CH       = 2,
    parameter int unsigned PERSIST_CYC = 20,
    parameter int unsigned TIMEOUT_W   = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          clear_i,
    input  logic [NB_CH-1:0]              event_i,
    input  logic [TIMEOUT_W-1:0]          timeout_cycles_i,
    output logic                          done_o,
    output logic                          done_pulse_o,
    output logic [$clog2(NB_CH+2)-1:0]    exit_code_o,
    output logic [TIMEOUT_W-1:0]          cycle_cnt_o,
    output logic [TIMEOUT_W-1:0]          exit_cycle_o
);

    localparam int unsigned CODE_W = $clog2(NB_CH + 2);

    state_e               state_q;
    logic                 run_active;
    logic [NB_CH-1:0]     confirm;
    logic                 chan_hit;
    logic [CODE_W-1:0]    chan_win_code;
    logic                 tmo_hit;
    logic                 enter_done;
    logic [TIMEOUT_W-1:0] cycle_cnt_inc;

    // A clear in RUN aborts the run, so the filters see it as disabled.
    assign run_active = (state_q == StRun) && !clear_i;

    for (genvar k = 0; k < NB_CH; k++) begin : g_filter
        exit_mon_filter #(
            .PERSIST_CYC (PERSIST_CYC)
        ) u_filter (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .en_i      (run_active),
            .event_i   (event_i[k]),
            .confirm_o (confirm[k])
        );
    end

    // Scan from the top so the lowest confirming index is left standing.
    always_comb begin
        chan_hit      = 1'b0;
        chan_win_code = CODE_W'(EXIT_NONE);
        for (int k = int'(NB_CH) - 1; k >= 0; k--) begin
            if (confirm[k]) begin
                chan_hit      = 1'b1;
                chan_win_code = CODE_W'(chan_code(unsigned'(k)));
            end
        end
    end

    assign tmo_hit = (timeout_cycles_i != '0) &&
                     (cycle_cnt_o == timeout_cycles_i - TIMEOUT_W'(1));

    assign cycle_cnt_inc = (cycle_cnt_o == '1) ? cycle_cnt_o : cycle_cnt_o + TIMEOUT_W'(1);
    assign enter_done    = run_active && (chan_hit || tmo_hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            done_o       <= 1'b0;
            done_pulse_o <= 1'b0;
            exit_code_o  <= CODE_W'(EXIT_NONE);
            cycle_cnt_o  <= '0;
        end else begin
            done_pulse_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!clear_i && start_i) begin
                        state_q     <= StRun;
                        cycle_cnt_o <= '0;
                    end
                end
                StRun: begin
                    if (clear_i) begin
                        state_q <= StIdle;
                    end else begin
                        cycle_cnt_o <= cycle_cnt_inc;
                        if (enter_done) begin
                            state_q      <= StDone;
                            done_o       <= 1'b1;
                            done_pulse_o <= 1'b1;
                            exit_code_o  <= chan_hit ? chan_win_code
                                                     : CODE_W'(timeout_code(NB_CH));
                        end
                    end
                end
                StDone: begin
                    if (clear_i) begin
                        state_q     <= StIdle;
                        done_o      <= 1'b0;
                        exit_code_o <= CODE_W'(EXIT_NONE);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef EXIT_MON_CYCLE_SNAPSHOT_EN
    logic [TIMEOUT_W-1:0] exit_cycle_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_cycle_q <= '0;
        end else if (clear_i) begin
            exit_cycle_q <= '0;
        end else if (enter_done) begin
            exit_cycle_q <= cycle_cnt_inc;
        end
    end

    assign exit_cycle_o = exit_cycle_q;
`else
    assign exit_cycle_o = '0;
`endif

endmodule
